// File: rtl/spi_host_master.sv
// Single-lane SPI mode-0 master issuing memory write (0x02) and read (0x0B) frames
// to the spi_device_tlul slave port from a valid/ready request interface.
module spi_host_master #(
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned DUMMY_CYCLES = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        busy_o,
    output logic        spi_sclk_o,
    output logic        spi_csn_o,
    output logic        spi_sdo_o,
    input  logic        spi_sdi_i
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CNT_MAX = (DUMMY_CYCLES > 32) ? DUMMY_CYCLES : 32;
    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h0B;

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, WDATA, DUMMY, RDATA, HOLD, DONE
    } state_t;

    state_t           state;
    state_t           next_field;
    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic [70:0]      tx_sr;
    logic [31:0]      rx_sr;
    logic             is_write;
    logic             div_tick;
    logic             field_last;
    logic [7:0]       cmd;

    assign div_tick = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign cmd      = req_write_i ? CMD_WRITE : CMD_READ;

    // Last bit of the current field and the field that follows it
    always_comb begin
        field_last = 1'b0;
        next_field = state;
        case (state)
            CMD: begin
                field_last = (bit_cnt == CNT_W'(7));
                next_field = ADDR;
            end
            ADDR: begin
                field_last = (bit_cnt == CNT_W'(31));
                if (is_write)
                    next_field = WDATA;
                else if (DUMMY_CYCLES == 0)
                    next_field = RDATA;
                else
                    next_field = DUMMY;
            end
            WDATA: begin
                field_last = (bit_cnt == CNT_W'(31));
                next_field = HOLD;
            end
            DUMMY: begin
                field_last = (bit_cnt == CNT_W'(DUMMY_CYCLES - 1));
                next_field = RDATA;
            end
            RDATA: begin
                field_last = (bit_cnt == CNT_W'(31));
                next_field = HOLD;
            end
            default: begin
                field_last = 1'b0;
                next_field = state;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            is_write    <= 1'b0;
            req_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            busy_o      <= 1'b0;
            spi_sclk_o  <= 1'b0;
            spi_csn_o   <= 1'b1;
            spi_sdo_o   <= 1'b0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (!req_ready_o) begin
                        req_ready_o <= 1'b1;
                    end else if (req_valid_i) begin
                        // Write data is zeroed on reads so SDO idles low after the address
                        is_write    <= req_write_i;
                        tx_sr       <= {cmd[6:0], req_addr_i, req_write_i ? req_wdata_i : 32'h0};
                        spi_sdo_o   <= cmd[7];
                        spi_csn_o   <= 1'b0;
                        spi_sclk_o  <= 1'b0;
                        busy_o      <= 1'b1;
                        req_ready_o <= 1'b0;
                        div_cnt     <= '0;
                        bit_cnt     <= '0;
                        state       <= CMD;
                    end
                end
                CMD, ADDR, WDATA, DUMMY, RDATA: begin
                    if (div_tick) begin
                        div_cnt    <= '0;
                        spi_sclk_o <= ~spi_sclk_o;
                        if (!spi_sclk_o) begin
                            if (state == RDATA)
                                rx_sr <= {rx_sr[30:0], spi_sdi_i};
                        end else begin
                            spi_sdo_o <= tx_sr[70];
                            tx_sr     <= {tx_sr[69:0], 1'b0};
                            if (field_last) begin
                                bit_cnt <= '0;
                                state   <= next_field;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                HOLD: begin
                    spi_sdo_o <= 1'b0;
                    if (div_tick) begin
                        div_cnt     <= '0;
                        spi_csn_o   <= 1'b1;
                        busy_o      <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        if (!is_write)
                            rsp_rdata_o <= rx_sr;
                        state <= DONE;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                DONE: begin
                    req_ready_o <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_host_master.sv
// Randomized bench for spi_host_master: a frame-level SPI slave model checks the
// bitstream, edge timing, read data and handshake timing on two parameterizations.
module tb_spi_host_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst       [2];
    logic        valid     [2];
    logic        ready     [2];
    logic        write     [2];
    logic [31:0] addr      [2];
    logic [31:0] wdata     [2];
    logic        rsp_valid [2];
    logic [31:0] rdata     [2];
    logic        busy      [2];
    logic        sclk      [2];
    logic        csn       [2];
    logic        sdo       [2];
    logic        sdi       [2];

    logic [31:0] exp_rdata [2];
    int n_vec = 0;
    int n_err = 0;

    spi_host_master #(.CLK_DIV(4), .DUMMY_CYCLES(32)) u_dut_def (
        .clk_i(clk), .rst_i(rst[0]), .req_valid_i(valid[0]), .req_ready_o(ready[0]),
        .req_write_i(write[0]), .req_addr_i(addr[0]), .req_wdata_i(wdata[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_rdata_o(rdata[0]), .busy_o(busy[0]),
        .spi_sclk_o(sclk[0]), .spi_csn_o(csn[0]), .spi_sdo_o(sdo[0]), .spi_sdi_i(sdi[0])
    );

    spi_host_master #(.CLK_DIV(1), .DUMMY_CYCLES(8)) u_dut_fast (
        .clk_i(clk), .rst_i(rst[1]), .req_valid_i(valid[1]), .req_ready_o(ready[1]),
        .req_write_i(write[1]), .req_addr_i(addr[1]), .req_wdata_i(wdata[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_rdata_o(rdata[1]), .busy_o(busy[1]),
        .spi_sclk_o(sclk[1]), .spi_csn_o(csn[1]), .spi_sdo_o(sdo[1]), .spi_sdi_i(sdi[1])
    );

    function automatic int div_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic int dum_of(input int d);
        return (d == 0) ? 32 : 8;
    endfunction

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Slave bit for frame position k: read-data bits come from the word, everything else is noise
    function automatic logic slave_bit(input int d, input bit wr, input int k, input logic [31:0] rw);
        int base;
        base = 40 + dum_of(d);
        if (!wr && k >= base && k < base + 32)
            return rw[31 - (k - base)];
        return 1'($urandom);
    endfunction

    // One full transaction on DUT d; called and returns at a negedge
    task automatic run_txn(input int d, input bit wr, input logic [31:0] a, input logic [31:0] w,
                           input logic [31:0] rw, input bit keep, input bit nwr,
                           input logic [31:0] na, input logic [31:0] nw,
                           input int exp_t, input int abort_at,
                           output int t_hs, output int done_cyc);
        int          dv, n, k, guard, edge_err, sdo_err, t, limit, seen;
        bit          prev;
        logic [7:0]  c;
        logic [71:0] exp_frame, got_frame;
        dv = div_of(d);
        n  = wr ? 72 : 72 + dum_of(d);
        c  = wr ? 8'h02 : 8'h0B;
        exp_frame = {c, a, wr ? w : 32'h0};
        got_frame = '0;
        done_cyc  = 0;
        valid[d] = 1'b1; write[d] = wr; addr[d] = a; wdata[d] = w;
        guard = 0;
        while (!ready[d] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        t = cyc;
        t_hs = t;
        if (guard >= 50) begin
            check("handshake_timeout", 72'(guard), 72'(0));
            valid[d] = 1'b0;
            return;
        end
        if (exp_t >= 0) check("handshake_cycle", 72'(t), 72'(exp_t));
        sdi[d] = slave_bit(d, wr, 0, rw);
        @(negedge clk);
        check("frame_start", 72'({csn[d], sclk[d], sdo[d], busy[d], ready[d]}),
              72'({1'b0, 1'b0, c[7], 1'b1, 1'b0}));
        if (!keep) valid[d] = 1'b0;
        prev = 1'b0; k = 0; edge_err = 0; sdo_err = 0;
        limit = t + 1 + (2 * n + 1) * dv + 40;
        while (csn[d] == 1'b0 && cyc < limit) begin
            if (cyc == t + 10) begin
                if (keep) begin
                    write[d] = nwr; addr[d] = na; wdata[d] = nw;
                end else begin
                    write[d] = 1'($urandom); addr[d] = $urandom; wdata[d] = $urandom;
                end
            end
            if (abort_at > 0 && cyc == t + abort_at) begin
                rst[d] = 1'b1;
                @(negedge clk);
                check("abort_pins", 72'({csn[d], sclk[d], sdo[d], busy[d], rsp_valid[d], ready[d]}),
                      72'(6'b100000));
                rst[d] = 1'b0;
                exp_rdata[d] = '0;
                seen = 0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    if (rsp_valid[d]) seen++;
                end
                check("abort_no_rsp", 72'(seen), 72'(0));
                check("abort_ready", 72'(ready[d]), 72'(1));
                done_cyc = cyc;
                return;
            end
            if (sclk[d] && !prev) begin
                if (cyc != t + 1 + (2 * k + 1) * dv) edge_err++;
                if (k < 72) got_frame[71 - k] = sdo[d];
                if (!wr && k >= 40 && sdo[d] !== 1'b0) sdo_err++;
                k++;
            end else if (!sclk[d] && prev) begin
                if (cyc != t + 1 + 2 * k * dv) edge_err++;
                sdi[d] = slave_bit(d, wr, k, rw);
            end
            prev = sclk[d];
            @(negedge clk);
        end
        done_cyc = cyc;
        if (csn[d] == 1'b0) begin
            check("done_timeout", 72'(cyc), 72'(limit));
            return;
        end
        check("done_cycle", 72'(cyc), 72'(t + 1 + (2 * n + 1) * dv));
        check("bit_count", 72'(k), 72'(n));
        check("edge_timing", 72'(edge_err), 72'(0));
        if (wr) begin
            check("wr_frame", got_frame, exp_frame);
        end else begin
            check("rd_frame_hdr", 72'(got_frame[71:32]), 72'(exp_frame[71:32]));
            check("rd_sdo_low", 72'(sdo_err), 72'(0));
            exp_rdata[d] = rw;
        end
        check("done_flags", 72'({rsp_valid[d], busy[d], sclk[d]}), 72'(3'b100));
        check("rsp_rdata", 72'(rdata[d]), 72'(exp_rdata[d]));
        @(negedge clk);
        check("idle_after", 72'({rsp_valid[d], ready[d], csn[d]}), 72'(3'b011));
    endtask

    initial begin
        int t, dn, t2, dn2;
        bit wr;
        logic [31:0] a, w, rw;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; valid[d] = 1'b0; write[d] = 1'b0;
            addr[d] = '0; wdata[d] = '0; sdi[d] = 1'b0; exp_rdata[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_pins", 72'({csn[d], sclk[d], sdo[d], rsp_valid[d], busy[d], ready[d]}),
                  72'(6'b100000));
            check("reset_rdata", 72'(rdata[d]), 72'(0));
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 72'({ready[0], ready[1]}), 72'(2'b11));

        // Default parameters: directed write and read
        run_txn(0, 1'b1, 32'd100, 32'd100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, -1, 0, t, dn);
        check("wr_latency", 72'(dn - t), 72'(581));
        run_txn(0, 1'b0, 32'd200, $urandom, 32'd200, 1'b0, 1'b0, 32'h0, 32'h0, -1, 0, t, dn);
        check("rd_latency", 72'(dn - t), 72'(837));

        // Back-to-back write then read with valid held high
        a = $urandom; w = $urandom; rw = $urandom;
        run_txn(0, 1'b1, a, w, 32'h0, 1'b1, 1'b0, 32'h1234, 32'h0, -1, 0, t, dn);
        run_txn(0, 1'b0, 32'h1234, 32'h0, rw, 1'b0, 1'b0, 32'h0, 32'h0, dn + 1, 0, t2, dn2);

        // Reset during the address field, then a clean write
        run_txn(0, 1'b1, $urandom, $urandom, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, -1, 1 + 2 * 12 * 4 + 3, t, dn);
        run_txn(0, 1'b1, $urandom, $urandom, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, -1, 0, t, dn);

        for (int i = 0; i < 4; i++) begin
            wr = 1'($urandom);
            run_txn(0, wr, $urandom, $urandom, $urandom, 1'b0, 1'b0, 32'h0, 32'h0, -1, 0, t, dn);
        end

        // CLK_DIV=1, DUMMY_CYCLES=8
        run_txn(1, 1'b0, $urandom, $urandom, 32'hA5A5_5A5A, 1'b0, 1'b0, 32'h0, 32'h0, -1, 0, t, dn);
        check("fast_rd_latency", 72'(dn - t), 72'(162));
        check("fast_rdata", 72'(rdata[1]), 72'(32'hA5A5_5A5A));
        for (int i = 0; i < 8; i++) begin
            wr = 1'($urandom);
            run_txn(1, wr, $urandom, $urandom, $urandom, 1'b0, 1'b0, 32'h0, 32'h0, -1, 0, t, dn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
